syscall_stat_unit: RTL and testbench
====================================

# syscall_stat_unit

Parametrised successor to the top-level's hard-wired syscall/LED logic. Sits beside the single-cycle core on the divided CPU clock: decodes syscall service codes from `$v0`, gates the PC enable, and implements a resumable halt. Keeps a DISP_CH-deep history of displayed `$a0` values and optional execution counters, all readable by the seven-segment driver through one registered select mux.

## Interface
Parameters:
- DATA_BITS, 32, width of `$v0`/`$a0`, history entries and display output
- CNT_BITS, 32, width of each statistics counter (CNT_BITS ≤ DATA_BITS)
- DISP_CH, 4, history depth; power of two, ≥ 2
- SEL_BITS, 3, width of `disp_sel`; 2^SEL_BITS ≥ DISP_CH+3
- V0_DISPLAY, 34, service code for "display `$a0`"

Ports:
- clk  in  1  CPU clock (divided clock from the top level)
- rst  in  1  reset; synchronous, active-high
- syscall  in  1  current instruction is SYSCALL
- reg_v0  in  DATA_BITS  live `$v0`
- reg_a0  in  DATA_BITS  live `$a0`
- is_jump  in  1  current instruction is J/JAL/JR
- br_taken  in  1  current conditional branch is taken
- resume  in  1  single-cycle resume pulse, already debounced
- disp_sel  in  SEL_BITS  display source select
- pc_en  out  1  PC register enable (combinational)
- halted  out  1  high in HALT
- disp_out  out  DATA_BITS  selected value, registered

## Operation
- `disp` = syscall & (reg_v0 == V0_DISPLAY); `stop` = syscall & ~disp.
- FSM states: RUN, HALT, RESUME. Reset → RUN.
  - RUN: pc_en = ~stop. If stop → HALT. The halting syscall does not commit: nothing is counted and the history is not written.
  - HALT: pc_en = 0; halted = 1. resume → RESUME; otherwise stay.
  - RESUME: pc_en = 1 unconditionally, stepping past the halting syscall; → RUN. Counts as one committed instruction.
- `commit` = pc_en. Every counter event and history write is qualified by commit.
- History: on commit & disp, hist[wr_ptr] ← reg_a0 and wr_ptr ← wr_ptr+1 mod DISP_CH (wraps silently, overwriting the oldest entry).
- Select map for disp_sel = s:
  - s < DISP_CH: s-th newest entry, hist[(wr_ptr−1−s) mod DISP_CH]. s=0 is the last displayed value. Unwritten entries read 0.
  - s = DISP_CH: instruction count.
  - s = DISP_CH+1: jump count.
  - s = DISP_CH+2: taken-branch count.
  - Counter values are zero-extended to DATA_BITS.
  - Any other s reads 0.
- Counters saturate at all-ones and never wrap:
  - instr increments on commit.
  - jump increments on commit & is_jump.
  - branch increments on commit & br_taken.
- resume is ignored in RUN and RESUME.

## Timing
- Reset values: state RUN; wr_ptr, all hist entries, all counters and disp_out = 0; halted = 0. pc_en = 1 unless syscall with a non-display code is present.
- pc_en and halted are combinational from state and inputs. A stop syscall drops pc_en in the same cycle it is decoded.
- disp_out latency is one clk: it reflects the disp_sel and storage contents sampled at the previous edge.
- A display syscall and a change of disp_sel in the same cycle: the next disp_out shows the pre-write history. The new value is visible one cycle later.
- Resume latency: resume high in cycle n → RESUME in n+1 (pc_en = 1) → RUN in n+2.
- rst in any state, including HALT or RESUME, returns to RUN with storage cleared at the next edge. rst has priority over resume and syscall.

## Configuration
- `SYSCALL_STAT_STATS_EN` defined: the three counters and their select codes are present.
- Undefined: counters are not instantiated; s = DISP_CH … DISP_CH+2 read 0. FSM, history and pc_en behaviour are unchanged.

## Test plan
- Reset release, no syscall, run 10 cycles with is_jump=1 on cycles 3 and 7 → disp_sel=DISP_CH gives 10, DISP_CH+1 gives 2, disp_out 0 at reset.
- Display syscalls with a0 = 0x11, 0x22, 0x33, 0x44, 0x55 (DISP_CH=4) → sel 0 gives 0x55, sel 3 gives 0x22, and 0x11 has been overwritten.
- Syscall with v0=10 → pc_en=0 same cycle, halted=1 next. Hold 5 cycles with counters frozen. Pulse resume → pc_en=1 for exactly one cycle, instr count +1, halted=0.
- Resume pulsed in RUN → no state change, pc_en stays 1.
- Preload counter near all-ones (CNT_BITS=4), run 20 commits → instr reads 0xF and holds.
- rst asserted while HALT → next cycle RUN, all select codes read 0. Build with macro undefined: sel DISP_CH reads 0 after 10 commits.

Source files
------------

// File: rtl/syscall_stat_unit.sv
// syscall_stat_unit
//
// Purpose:
//   Syscall decode and run/halt control for the single-cycle core. It
//   decodes the syscall service code in $v0, gates the PC enable and
//   implements a halt that a resume pulse can release. It also keeps a
//   DISP_CH-deep history of displayed $a0 values and, optionally,
//   saturating execution counters. All of these are read through one
//   registered select mux that feeds the seven-segment driver.
//
// Configuration macro:
//   SYSCALL_STAT_STATS_EN - when defined, the instruction, jump and
//   taken-branch counters are built and readable at select codes
//   DISP_CH..DISP_CH+2. When undefined, those codes read zero.
//
// Ports:
//   clk      in   CPU clock (divided clock)
//   rst      in   synchronous active-high reset
//   syscall  in   current instruction is SYSCALL
//   reg_v0   in   live $v0 (service code)
//   reg_a0   in   live $a0 (value to display)
//   is_jump  in   current instruction is J/JAL/JR
//   br_taken in   current conditional branch is taken
//   resume   in   debounced single-cycle resume pulse
//   disp_sel in   display source select
//   pc_en    out  PC register enable (combinational)
//   halted   out  high while halted (combinational from state)
//   disp_out out  selected display value (registered)

module syscall_stat_unit #(
   parameter int DATA_BITS  = 32,
   parameter int CNT_BITS   = 32,
   parameter int DISP_CH    = 4,
   parameter int SEL_BITS   = 3,
   parameter int V0_DISPLAY = 34
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 syscall,
   input  logic [DATA_BITS-1:0] reg_v0,
   input  logic [DATA_BITS-1:0] reg_a0,
   input  logic                 is_jump,
   input  logic                 br_taken,
   input  logic                 resume,
   input  logic [SEL_BITS-1:0]  disp_sel,
   output logic                 pc_en,
   output logic                 halted,
   output logic [DATA_BITS-1:0] disp_out
);

   localparam int PTR_BITS = $clog2(DISP_CH);
   localparam logic [DATA_BITS-1:0] V0_CODE = DATA_BITS'(V0_DISPLAY);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_HALT,
      ST_RESUME
   } state_t;

   state_t                state_q, state_d;
   logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DATA_BITS-1:0]  hist_q [DISP_CH];
   logic [DATA_BITS-1:0]  hist_d [DISP_CH];
   logic [DATA_BITS-1:0]  disp_out_q, disp_out_d;
   logic [PTR_BITS-1:0]   rd_idx;
   logic                  disp;
   logic                  stop;
   logic                  commit;

   assign disp   = syscall & (reg_v0 == V0_CODE);
   assign stop   = syscall & ~disp;
   assign commit = pc_en;

   // Run/halt control. The halting syscall is held off in RUN (pc_en low);
   // the RESUME state then lets it commit so the PC steps past it.
   always_comb begin
      state_d = state_q;
      pc_en   = 1'b1;
      halted  = 1'b0;
      case (state_q)
         ST_RUN: begin
            pc_en = ~stop;
            if (stop) state_d = ST_HALT;
         end
         ST_HALT: begin
            pc_en  = 1'b0;
            halted = 1'b1;
            if (resume) state_d = ST_RESUME;
         end
         ST_RESUME: begin
            pc_en   = 1'b1;
            state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Display history: a circular buffer. Once full, the oldest entry is
   // overwritten silently.
   always_comb begin
      hist_d   = hist_q;
      wr_ptr_d = wr_ptr_q;
      if (commit && disp) begin
         hist_d[wr_ptr_q] = reg_a0;
         wr_ptr_d         = wr_ptr_q + PTR_BITS'(1);
      end
   end

   // Select s reads the s-th newest entry. DISP_CH is a power of two, so
   // the wrap modulo is just the natural truncation of the pointer width.
   assign rd_idx = wr_ptr_q - PTR_BITS'(1) - disp_sel[PTR_BITS-1:0];

`ifdef SYSCALL_STAT_STATS_EN
   logic [CNT_BITS-1:0] instr_q, instr_d;
   logic [CNT_BITS-1:0] jump_q, jump_d;
   logic [CNT_BITS-1:0] branch_q, branch_d;

   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v,
                                                   input logic              en);
      return (en && (v != '1)) ? v + CNT_BITS'(1) : v;
   endfunction

   // Counters stick at all-ones rather than wrapping.
   always_comb begin
      instr_d  = sat_inc(instr_q, commit);
      jump_d   = sat_inc(jump_q, commit & is_jump);
      branch_d = sat_inc(branch_q, commit & br_taken);
   end
`else
   logic unused_stats;
   assign unused_stats = is_jump ^ br_taken;
`endif

   // Output select mux. It samples the storage before this edge's writes,
   // so a display syscall becomes visible one cycle after it commits.
   always_comb begin
      disp_out_d = '0;
      if (int'(disp_sel) < DISP_CH) begin
         disp_out_d = hist_q[rd_idx];
      end
`ifdef SYSCALL_STAT_STATS_EN
      else if (disp_sel == SEL_BITS'(DISP_CH)) begin
         disp_out_d = DATA_BITS'(instr_q);
      end
      else if (disp_sel == SEL_BITS'(DISP_CH + 1)) begin
         disp_out_d = DATA_BITS'(jump_q);
      end
      else if (disp_sel == SEL_BITS'(DISP_CH + 2)) begin
         disp_out_d = DATA_BITS'(branch_q);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         wr_ptr_q   <= '0;
         disp_out_q <= '0;
         for (int i = 0; i < DISP_CH; i++) begin
            hist_q[i] <= '0;
         end
`ifdef SYSCALL_STAT_STATS_EN
         instr_q  <= '0;
         jump_q   <= '0;
         branch_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         disp_out_q <= disp_out_d;
         hist_q     <= hist_d;
`ifdef SYSCALL_STAT_STATS_EN
         instr_q  <= instr_d;
         jump_q   <= jump_d;
         branch_q <= branch_d;
`endif
      end
   end

   assign disp_out = disp_out_q;

endmodule

// File: tb/tb_syscall_stat_unit.sv
// tb_syscall_stat_unit
//
// Directed bench for syscall_stat_unit. The stimulus thread drives one
// cycle at a time and queues the values it expects, tagged with the cycle
// in which they should be seen. A monitor on the falling edge pops every
// entry due in that cycle and compares it. A second instance with 4-bit
// counters shares the same stimulus and exercises counter saturation.

module tb_syscall_stat_unit;

   localparam int PC_EN = 0;
   localparam int HALTED = 1;
   localparam int DISP  = 2;
   localparam int SAT   = 3;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] value;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        syscall;
   logic [31:0] reg_v0;
   logic [31:0] reg_a0;
   logic        is_jump;
   logic        br_taken;
   logic        resume;
   logic [2:0]  disp_sel;
   logic        pc_en;
   logic        halted;
   logic [31:0] disp_out;
   logic        sat_pc_en;
   logic        sat_halted;
   logic [31:0] sat_disp_out;

   exp_t sb[$];
   int   cyc;
   int   n_compared;
   int   n_mismatched;

   syscall_stat_unit #(
      .DATA_BITS(32), .CNT_BITS(32), .DISP_CH(4), .SEL_BITS(3), .V0_DISPLAY(34)
   ) dut (
      .clk(clk), .rst(rst), .syscall(syscall), .reg_v0(reg_v0), .reg_a0(reg_a0),
      .is_jump(is_jump), .br_taken(br_taken), .resume(resume), .disp_sel(disp_sel),
      .pc_en(pc_en), .halted(halted), .disp_out(disp_out)
   );

   // Narrow-counter instance; its select is tied to the instruction count.
   syscall_stat_unit #(
      .DATA_BITS(32), .CNT_BITS(4), .DISP_CH(4), .SEL_BITS(3), .V0_DISPLAY(34)
   ) dut_sat (
      .clk(clk), .rst(rst), .syscall(syscall), .reg_v0(reg_v0), .reg_a0(reg_a0),
      .is_jump(is_jump), .br_taken(br_taken), .resume(resume), .disp_sel(3'd4),
      .pc_en(sat_pc_en), .halted(sat_halted), .disp_out(sat_disp_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle number; a cycle runs from one rising edge to the next.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Counter readings collapse to zero when the statistics are not built.
   function automatic logic [31:0] cnt(input int v);
`ifdef SYSCALL_STAT_STATS_EN
      return 32'(v);
`else
      return (v > 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   function automatic void push_expect(input string name, input int kind,
                                       input logic [31:0] value, input int offset);
      exp_t e;
      e.cyc   = cyc + offset;
      e.kind  = kind;
      e.value = value;
      e.name  = name;
      sb.push_back(e);
   endfunction

   task automatic checkOutput(input exp_t e);
      logic [31:0] actual;
      case (e.kind)
         PC_EN:   actual = {31'd0, pc_en};
         HALTED:  actual = {31'd0, halted};
         DISP:    actual = disp_out;
         default: actual = sat_disp_out;
      endcase
      n_compared++;
      if (actual !== e.value) begin
         n_mismatched++;
         $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h",
                  e.name, e.cyc, actual, e.value);
      end
   endtask

   // Monitor: compare every queued expectation that falls due this cycle.
   always @(negedge clk) begin : monitor
      int i;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].cyc == cyc) begin
            checkOutput(sb[i]);
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   // Drives one cycle of inputs, then advances to just after the next edge.
   task automatic applyStimulus(input logic r, input logic sc, input logic [31:0] v0,
                                input logic [31:0] a0, input logic j, input logic b,
                                input logic res, input logic [2:0] sel);
      rst      = r;
      syscall  = sc;
      reg_v0   = v0;
      reg_a0   = a0;
      is_jump  = j;
      br_taken = b;
      resume   = res;
      disp_sel = sel;
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected end");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      logic [31:0] vals[4];
      logic [2:0]  sels[7];
      vals = '{32'h11, 32'h22, 32'h33, 32'h44};
      sels = '{3'd5, 3'd6, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
      n_compared   = 0;
      n_mismatched = 0;
      rst = 1'b1; syscall = 1'b0; reg_v0 = '0; reg_a0 = '0;
      is_jump = 1'b0; br_taken = 1'b0; resume = 1'b0; disp_sel = '0;
      @(posedge clk);
      #1;

      // Reset.
      push_expect("rst_pc_en", PC_EN, 1, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      push_expect("rst_disp_out", DISP, 0, 1);
      push_expect("rst_halted", HALTED, 0, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

      // Ten plain commits, jumps on 3 and 7, a taken branch on 5.
      for (int k = 1; k <= 10; k++) begin
         if (k == 2) push_expect("hist_unwritten", DISP, 0, 1);
         applyStimulus(0, 0, 0, 0, (k == 3 || k == 7), (k == 5), 0, 0);
      end
      push_expect("instr_10", DISP, cnt(10), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 4);
      push_expect("jump_2", DISP, cnt(2), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 5);
      push_expect("branch_1", DISP, cnt(1), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 6);

      // Display syscalls; the fifth one overwrites 0x11.
      for (int k = 0; k < 4; k++) begin
         push_expect("disp_pc_en", PC_EN, 1, 0);
         applyStimulus(0, 1, 34, vals[k], 0, 0, 0, 0);
      end
      push_expect("same_cycle_prewrite", DISP, 32'h44, 1);
      applyStimulus(0, 1, 34, 32'h55, 0, 0, 0, 0);
      push_expect("hist_s0", DISP, 32'h55, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      push_expect("hist_s1", DISP, 32'h44, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      push_expect("hist_s2", DISP, 32'h33, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 2);
      push_expect("hist_s3", DISP, 32'h22, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3);
      push_expect("sel7_zero", DISP, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 7);

      // Stop syscall, five held cycles, then resume. Count is 23 here.
      push_expect("stop_pc_en", PC_EN, 0, 0);
      push_expect("stop_halted", HALTED, 1, 1);
      push_expect("stop_count", DISP, cnt(23), 1);
      applyStimulus(0, 1, 10, 0, 0, 0, 0, 4);
      for (int k = 0; k < 5; k++) begin
         push_expect("halt_pc_en", PC_EN, 0, 0);
         push_expect("halt_halted", HALTED, 1, 0);
         push_expect("halt_frozen", DISP, cnt(23), 1);
         applyStimulus(0, 1, 10, 0, 1, 1, 0, 4);
      end
      push_expect("resume_pulse_pc_en", PC_EN, 0, 0);
      applyStimulus(0, 1, 10, 0, 0, 0, 1, 4);
      push_expect("resume_pc_en", PC_EN, 1, 0);
      push_expect("resume_halted", HALTED, 0, 0);
      push_expect("resume_pre_count", DISP, cnt(23), 0);
      applyStimulus(0, 1, 10, 0, 0, 0, 0, 4);
      push_expect("after_resume_pc_en", PC_EN, 1, 0);
      push_expect("after_resume_halted", HALTED, 0, 0);
      push_expect("resume_counted", DISP, cnt(24), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 4);

      // Resume pulsed while running has no effect.
      push_expect("run_resume_pc_en", PC_EN, 1, 0);
      push_expect("run_resume_halted", HALTED, 0, 1);
      push_expect("run_resume_count", DISP, cnt(25), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 4);
      push_expect("run_resume_next_pc_en", PC_EN, 1, 0);
      push_expect("run_resume_next_count", DISP, cnt(26), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 4);
      push_expect("jump_frozen_in_halt", DISP, cnt(2), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 5);
      push_expect("branch_frozen_in_halt", DISP, cnt(1), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 6);

      // Halt again, then reset while halted (with resume and a display
      // syscall present, both of which reset must override).
      push_expect("stop2_pc_en", PC_EN, 0, 0);
      applyStimulus(0, 1, 10, 0, 0, 0, 0, 0);
      push_expect("stop2_halted", HALTED, 1, 0);
      applyStimulus(1, 1, 34, 32'h99, 0, 0, 1, 0);
      push_expect("rst_halt_pc_en", PC_EN, 1, 0);
      push_expect("rst_halt_halted", HALTED, 0, 0);
      push_expect("rst_halt_disp_clear", DISP, 0, 0);
      push_expect("rst_halt_instr", DISP, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 4);
      for (int k = 0; k < 7; k++) begin
         push_expect("rst_halt_sel_zero", DISP, 0, 1);
         applyStimulus(0, 0, 0, 0, 0, 0, 0, sels[k]);
      end

      // Twenty more commits: the 4-bit counter climbs, then sticks at 0xF.
      for (int k = 1; k <= 20; k++) begin
         if (k == 5)  push_expect("sat_counting", SAT, cnt(12), 1);
         if (k == 12) push_expect("sat_reached", SAT, cnt(15), 1);
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 4);
      end
      push_expect("sat_holds", SAT, cnt(15), 1);
      push_expect("instr_after_reset", DISP, cnt(28), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 4);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      while (sb.size() > 0) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL %s: got no sample, expected 0x%0h at cycle %0d",
                  sb[0].name, sb[0].value, sb[0].cyc);
         void'(sb.pop_front());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
